fm_demod_top: RTL and testbench

// - FM quadrature demodulator stage of the FM radio chain.
// - Accepts complex baseband samples (real/imag, Q10 fixed point) from the channel FIR stage.
// - Computes the phase difference between consecutive samples using a quantized arctangent, then scales it by the demod gain.
// - Buffers the 32-bit demodulated audio in an output FIFO for the downstream audio filters.

---
 rtl/fm_demod_top.sv | 344 ++++++++++++++++++++++++++++++++++
 tb/tb_fm_demod_top.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fm_demod_top.sv
// rtl/fm_demod_top.sv - FM quadrature demodulator with input and output sample FIFOs
//
// fm_demod_fifo : synchronous-write, first-word-fall-through FIFO
//   clk, reset          clock, asynchronous active-high reset
//   wr_en, wr_data      push (ignored when full unless a pop happens in the same cycle)
//   rd_en, rd_data      pop (ignored when empty); rd_data is the head, 0 when empty
//   full, empty         fill status
//
// fm_demod_top : FM demodulator stage
//   clk, reset          clock, asynchronous active-high reset
//   real_in, imag_in    complex input sample (Q10, signed)
//   in_fifo_wr_en       push {real_in, imag_in}
//   in_fifos_full       either input FIFO full
//   out_fifo_rd_en      pop the output FIFO head
//   data_out            output FIFO head (valid while out_fifo_empty=0)
//   out_fifo_empty      output FIFO empty

module fm_demod_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_ok   = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
    assign wr_ok   = wr_en && (!full || rd_en);
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end
endmodule

module fm_demod_top #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int BITS       = 10,
    parameter int GAIN       = 758,
    parameter int QUAD1      = 804,
    parameter int QUAD3      = 2412
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] real_in,
    input  logic [DATA_WIDTH-1:0] imag_in,
    input  logic                  in_fifo_wr_en,
    output logic                  in_fifos_full,
    input  logic                  out_fifo_rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  out_fifo_empty
);
    localparam int W  = DATA_WIDTH;
    localparam int PW = 2 * DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH) + 1;

    localparam logic signed [PW-1:0] RND     = PW'((1 << BITS) - 1);
    localparam logic signed [PW-1:0] GAIN_X  = PW'(GAIN);
    localparam logic signed [PW-1:0] QUAD1_X = PW'(QUAD1);
    localparam logic signed [W-1:0]  QUAD1_W = W'(QUAD1);
    localparam logic signed [W-1:0]  QUAD3_W = W'(QUAD3);
    localparam logic signed [W-1:0]  ONE_W   = W'(1);
    localparam logic [CW-1:0]        CNT_INIT = CW'(W);
    localparam logic [CW-1:0]        CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        ATAN_PREP,
        DIV,
        SCALE,
        WRITE
    } state_t;

    // Dequantize: divide by 2^BITS rounding toward zero. Negative values are biased
    // by 2^BITS-1 before the arithmetic shift so they do not round toward -inf.
    function automatic logic signed [W-1:0] deq(input logic signed [PW-1:0] v);
        logic signed [PW-1:0] adj;
        adj = v[PW-1] ? (v + RND) : v;
        return W'(adj >>> BITS);
    endfunction

    function automatic logic signed [PW-1:0] sx(input logic [W-1:0] a);
        return {{(PW-W){a[W-1]}}, a};
    endfunction

    state_t state;
    state_t next_state;

    logic [W-1:0] head_real;
    logic [W-1:0] head_imag;
    logic         real_full;
    logic         imag_full;
    logic         real_empty;
    logic         imag_empty;
    logic         in_empty;
    logic         out_full;
    logic         in_pop;
    logic         out_push;

    logic signed [W-1:0] cur_real;
    logic signed [W-1:0] cur_imag;
    logic signed [W-1:0] prev_real;
    logic signed [W-1:0] prev_imag;
    logic signed [W-1:0] x_val;
    logic signed [W-1:0] y_val;
    logic signed [W-1:0] out_val;

    logic [W-1:0]  dvd;
    logic [W-1:0]  dvs;
    logic [W:0]    rem;
    logic [W-1:0]  quot;
    logic          q_neg;
    logic          x_neg;
    logic [CW-1:0] cnt;

    // Phase-difference products
    logic signed [PW-1:0] neg_pimag;
    logic signed [PW-1:0] p_rr;
    logic signed [PW-1:0] p_ii;
    logic signed [PW-1:0] p_ri;
    logic signed [PW-1:0] p_ir;

    // Arctangent setup
    logic signed [W-1:0] y_abs;
    logic signed [W-1:0] ay;
    logic signed [W-1:0] num_pre;
    logic signed [W-1:0] num;
    logic signed [W-1:0] den;
    logic [W-1:0]        num_mag;
    logic [W-1:0]        den_mag;

    // Divider step
    logic [W+1:0] rem_sh;
    logic [W+1:0] diff;
    logic         ge;

    // Scaling
    logic signed [W-1:0] q_s;
    logic signed [W-1:0] base;
    logic signed [W-1:0] ang0;
    logic signed [W-1:0] ang;
    logic signed [W-1:0] scaled;

    // Both input FIFOs are written and popped together, so they stay aligned.
    fm_demod_fifo #(.WIDTH(W), .DEPTH(FIFO_DEPTH)) u_real_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (in_fifo_wr_en),
        .wr_data (real_in),
        .rd_en   (in_pop),
        .rd_data (head_real),
        .full    (real_full),
        .empty   (real_empty)
    );

    fm_demod_fifo #(.WIDTH(W), .DEPTH(FIFO_DEPTH)) u_imag_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (in_fifo_wr_en),
        .wr_data (imag_in),
        .rd_en   (in_pop),
        .rd_data (head_imag),
        .full    (imag_full),
        .empty   (imag_empty)
    );

    fm_demod_fifo #(.WIDTH(W), .DEPTH(FIFO_DEPTH)) u_out_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (out_push),
        .wr_data (out_val),
        .rd_en   (out_fifo_rd_en),
        .rd_data (data_out),
        .full    (out_full),
        .empty   (out_fifo_empty)
    );

    assign in_fifos_full = real_full | imag_full;
    assign in_empty      = real_empty | imag_empty;

    always_comb begin
        neg_pimag = -sx(prev_imag);
        p_rr      = sx(prev_real) * sx(cur_real);
        p_ii      = neg_pimag * sx(cur_imag);
        p_ri      = sx(prev_real) * sx(cur_imag);
        p_ir      = neg_pimag * sx(cur_real);
    end

    // ay = |y|+1 keeps the denominator nonzero; all of this wraps at W bits.
    always_comb begin
        y_abs   = y_val[W-1] ? -y_val : y_val;
        ay      = y_abs + ONE_W;
        num_pre = x_val[W-1] ? (x_val + ay) : (x_val - ay);
        num     = num_pre <<< BITS;
        den     = x_val[W-1] ? (ay - x_val) : (x_val + ay);
        num_mag = num[W-1] ? -num : num;
        den_mag = den[W-1] ? -den : den;
    end

    // Restoring divider on magnitudes; the top bit of diff flags a failed subtract.
    always_comb begin
        rem_sh = {rem, dvd[W-1]};
        diff   = rem_sh - {2'b00, dvs};
        ge     = ~diff[W+1];
    end

    always_comb begin
        q_s    = q_neg ? -quot : quot;
        base   = x_neg ? QUAD3_W : QUAD1_W;
        ang0   = base - deq(QUAD1_X * sx(q_s));
        ang    = y_val[W-1] ? -ang0 : ang0;
        scaled = deq(GAIN_X * sx(ang));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_pop     = 1'b0;
        out_push   = 1'b0;
        case (state)
            IDLE: begin
                if (!in_empty) begin
                    in_pop     = 1'b1;
                    next_state = MUL;
                end
            end
            MUL:       next_state = ATAN_PREP;
            ATAN_PREP: next_state = DIV;
            DIV: begin
                if (cnt == CNT_ONE) begin
                    next_state = SCALE;
                end
            end
            SCALE:     next_state = WRITE;
            WRITE: begin
                if (!out_full) begin
                    out_push   = 1'b1;
                    next_state = IDLE;
                end
            end
            default:   next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_real  <= '0;
            cur_imag  <= '0;
            prev_real <= '0;
            prev_imag <= '0;
            x_val     <= '0;
            y_val     <= '0;
            out_val   <= '0;
            dvd       <= '0;
            dvs       <= '0;
            rem       <= '0;
            quot      <= '0;
            q_neg     <= 1'b0;
            x_neg     <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_pop) begin
                        cur_real <= head_real;
                        cur_imag <= head_imag;
                    end
                end
                MUL: begin
                    x_val <= deq(p_rr) - deq(p_ii);
                    y_val <= deq(p_ri) + deq(p_ir);
                end
                ATAN_PREP: begin
                    dvd   <= num_mag;
                    dvs   <= den_mag;
                    rem   <= '0;
                    quot  <= '0;
                    q_neg <= num[W-1] ^ den[W-1];
                    x_neg <= x_val[W-1];
                    cnt   <= CNT_INIT;
                end
                DIV: begin
                    dvd  <= dvd << 1;
                    rem  <= ge ? diff[W:0] : rem_sh[W:0];
                    quot <= {quot[W-2:0], ge};
                    cnt  <= cnt - CNT_ONE;
                end
                SCALE: begin
                    out_val <= scaled;
                end
                WRITE: begin
                    if (out_push) begin
                        prev_real <= cur_real;
                        prev_imag <= cur_imag;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fm_demod_top.sv
// tb/tb_fm_demod_top.sv - scoreboard bench for fm_demod_top
module tb_fm_demod_top;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] real_in = '0;
    logic [31:0] imag_in = '0;
    logic        in_fifo_wr_en = 1'b0;
    logic        in_fifos_full;
    logic        out_fifo_rd_en = 1'b0;
    logic [31:0] data_out;
    logic        out_fifo_empty;

    int checks = 0;
    int failures = 0;
    int exp_q[$];
    int prev_r = 0;
    int prev_i = 0;
    bit saw_full = 1'b0;
    int lat;

    fm_demod_top dut (
        .clk            (clk),
        .reset          (reset),
        .real_in        (real_in),
        .imag_in        (imag_in),
        .in_fifo_wr_en  (in_fifo_wr_en),
        .in_fifos_full  (in_fifos_full),
        .out_fifo_rd_en (out_fifo_rd_en),
        .data_out       (data_out),
        .out_fifo_empty (out_fifo_empty)
    );

    always #5 clk = ~clk;

    function automatic int deq_m(input longint v);
        return int'(v / 64'sd1024);
    endfunction

    function automatic int model(input int pr, input int pi, input int cr, input int ci);
        int r, i, ay, num, den, q, ang;
        r  = deq_m(longint'(pr) * longint'(cr)) - deq_m(-longint'(pi) * longint'(ci));
        i  = deq_m(longint'(pr) * longint'(ci)) + deq_m(-longint'(pi) * longint'(cr));
        ay = ((i < 0) ? -i : i) + 1;
        if (r >= 0) begin
            num = (r - ay) << 10;
            den = r + ay;
            q   = num / den;
            ang = 804 - deq_m(longint'(804) * longint'(q));
        end else begin
            num = (r + ay) << 10;
            den = ay - r;
            q   = num / den;
            ang = 2412 - deq_m(longint'(804) * longint'(q));
        end
        if (i < 0) ang = -ang;
        return deq_m(longint'(758) * longint'(ang));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int r, input int i);
        int guard = 0;
        @(negedge clk);
        while (in_fifos_full && guard < 2000) begin
            saw_full = 1'b1;
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) check("in_full_timeout", 32'(guard), 32'd0);
        real_in       = r;
        imag_in       = i;
        in_fifo_wr_en = 1'b1;
        exp_q.push_back(model(prev_r, prev_i, r, i));
        prev_r = r;
        prev_i = i;
        @(negedge clk);
        in_fifo_wr_en = 1'b0;
    endtask

    task automatic pop_check(input string tag);
        int guard = 0;
        int e;
        while (out_fifo_empty && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 400) begin
            check({tag, "_timeout"}, 32'(guard), 32'd0);
        end else if (exp_q.size() == 0) begin
            check({tag, "_extra_output"}, data_out, 32'hDEADBEEF);
            out_fifo_rd_en = 1'b1;
            @(negedge clk);
            out_fifo_rd_en = 1'b0;
        end else begin
            e = exp_q.pop_front();
            check(tag, data_out, 32'(e));
            out_fifo_rd_en = 1'b1;
            @(negedge clk);
            out_fifo_rd_en = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #2;
        check("rst_async_empty", 32'(out_fifo_empty), 32'd1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        prev_r = 0;
        prev_i = 0;
        @(negedge clk);
        check("rst_in_full", 32'(in_fifos_full), 32'd0);
        check("rst_out_empty", 32'(out_fifo_empty), 32'd1);
        check("rst_data_out", data_out, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_full", 32'(in_fifos_full), 32'd0);
        check("rst_out_empty", 32'(out_fifo_empty), 32'd1);
        check("rst_data_out", data_out, 32'd0);

        // First sample after reset, with latency measurement.
        drive(1024, 0);
        lat = 0;
        while (out_fifo_empty && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("latency_le_45", 32'(lat <= 45), 32'd1);
        check("first_1190", data_out, 32'h000004A6);
        pop_check("first_sb");

        // Zero phase step, repeated.
        for (int k = 0; k < 3; k++) drive(1024, 0);
        for (int k = 0; k < 3; k++) pop_check("zero_step");

        // +90 degree step.
        drive(1024, 0);
        pop_check("p90_a");
        drive(0, 1024);
        while (out_fifo_empty) @(negedge clk);
        check("p90_literal", data_out, 32'd1190);
        pop_check("p90_b");

        // -90 degree step.
        drive(1024, 0);
        pop_check("m90_a");
        drive(0, -1024);
        while (out_fifo_empty) @(negedge clk);
        check("m90_literal", data_out, 32'hFFFFFB5A);
        pop_check("m90_b");

        // Stream of 100 samples, reader pops whenever data is present.
        saw_full = 1'b0;
        fork
            begin : stream_drv
                int sr, si;
                for (int k = 0; k < 100; k++) begin
                    sr = int'($urandom_range(4095, 0)) - 2048;
                    si = int'($urandom_range(4095, 0)) - 2048;
                    drive(sr, si);
                end
            end
            begin : stream_rd
                for (int k = 0; k < 100; k++) pop_check("stream");
            end
        join
        check("stream_saw_in_full", 32'(saw_full), 32'd1);
        check("stream_sb_empty", 32'(exp_q.size()), 32'd0);
        repeat (60) @(negedge clk);
        check("stream_out_empty", 32'(out_fifo_empty), 32'd1);

        // Output backpressure: 20 samples with no reads, then drain in order.
        for (int k = 0; k < 20; k++) drive(100 * k - 900, 1500 - 70 * k);
        repeat (1000) @(negedge clk);
        check("stall_out_nonempty", 32'(out_fifo_empty), 32'd0);
        check("stall_in_not_full", 32'(in_fifos_full), 32'd0);
        for (int k = 0; k < 20; k++) pop_check("drain");
        repeat (60) @(negedge clk);
        check("drain_out_empty", 32'(out_fifo_empty), 32'd1);
        check("drain_data_zero", data_out, 32'd0);

        // Reset in the middle of a stream discards everything in flight.
        for (int k = 0; k < 6; k++) drive(700 + k * 50, -300 + k * 90);
        repeat (50) @(negedge clk);
        do_reset();
        repeat (60) @(negedge clk);
        check("post_rst_still_empty", 32'(out_fifo_empty), 32'd1);
        drive(1024, 0);
        while (out_fifo_empty && lat < 1000) begin
            @(negedge clk);
            lat++;
        end
        check("post_rst_1190", data_out, 32'd1190);
        pop_check("post_rst_sb");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
